mem_port_arbiter: RTL and testbench

Sequences and shares the single unified memory port between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). Each cycle it grants at most one access, drives the memory port's address, write data, control and enable, and steers the one-cycle-latency read data back to the requester that owns it. It uses fixed data-over-fetch priority with a starvation limit, and generates the pipeline stall. It sits between the IF/MEM pipeline stages and the memory instance in the top-level core.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/arb_starve_cnt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core types for the unified memory port arbiter: memory control word,
// response-owner encoding and the fetch-side control constant.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STARVE_W = 4;

  typedef struct packed {
    logic [1:0] size;
    logic       sign;
    logic       memWrite;
  } mem_ctrl_t;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_RSP_NONE  = 2'd0,
    ARB_RSP_IF    = 2'd1,
    ARB_RSP_MEM   = 2'd2,
    ARB_RSP_MEMWR = 2'd3
  } arb_rsp_t;

  // Fetches are always unsigned word reads.
  localparam mem_ctrl_t FETCH_CTRL = '{size: MEM_SIZE_WORD, sign: 1'b0, memWrite: 1'b0};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the memory port.
// slave = the arbiter, master = pipeline stages plus memory instance.
interface mem_port_arbiter_if #(
  parameter int unsigned CNT_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic             i_ifReq;
  logic [XLEN-1:0]  i_ifAddr;
  logic             o_ifGnt;
  logic             o_ifValid;
  logic [XLEN-1:0]  o_ifData;

  logic             i_memReq;
  logic [XLEN-1:0]  i_memAddr;
  logic [XLEN-1:0]  i_memWData;
  mem_ctrl_t        i_ctrlMEM;
  logic             o_memGnt;
  logic             o_memValid;
  logic [XLEN-1:0]  o_memRData;

  logic             o_portEn;
  logic [XLEN-1:0]  o_portAddr;
  logic [XLEN-1:0]  o_portWData;
  mem_ctrl_t        o_portCtrl;
  logic [XLEN-1:0]  i_portRData;

  logic             o_stall;
  logic [CNT_W-1:0] o_cntConflict;
  logic [CNT_W-1:0] o_cntIfDeny;
  logic [CNT_W-1:0] o_cntMemDeny;

  modport slave (
    input  i_ifReq, i_ifAddr, i_memReq, i_memAddr, i_memWData, i_ctrlMEM, i_portRData,
    output o_ifGnt, o_ifValid, o_ifData, o_memGnt, o_memValid, o_memRData,
           o_portEn, o_portAddr, o_portWData, o_portCtrl, o_stall,
           o_cntConflict, o_cntIfDeny, o_cntMemDeny
  );

  modport master (
    output i_ifReq, i_ifAddr, i_memReq, i_memAddr, i_memWData, i_ctrlMEM, i_portRData,
    input  o_ifGnt, o_ifValid, o_ifData, o_memGnt, o_memValid, o_memRData,
           o_portEn, o_portAddr, o_portWData, o_portCtrl, o_stall,
           o_cntConflict, o_cntIfDeny, o_cntMemDeny
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; at_limit_c lets fetch
// win the next conflict.
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic if_req,
  input  logic if_gnt,
  output logic at_limit_c
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)              cnt_q <= '0;
    else if (!if_req || if_gnt)  cnt_q <= '0;
    else if (cnt_q != LIMIT)     cnt_q <= cnt_q + STARVE_W'(1);
  end

  assign at_limit_c = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between fetch and load/store: data-over-fetch
// priority with starvation escape, response steering, stall. ARB_PERF_COUNTERS_EN adds counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] RSP_NONE  = 2'(ARB_RSP_NONE);
  localparam logic [1:0] RSP_IF    = 2'(ARB_RSP_IF);
  localparam logic [1:0] RSP_MEM   = 2'(ARB_RSP_MEM);
  localparam logic [1:0] RSP_MEMWR = 2'(ARB_RSP_MEMWR);

  logic       starve_hit_c;
  logic       if_gnt_c;
  logic       mem_gnt_c;
  logic [1:0] rsp_q;
  logic [1:0] rsp_d;

  arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .if_req     (bus.i_ifReq),
    .if_gnt     (if_gnt_c),
    .at_limit_c (starve_hit_c)
  );

  // Data wins conflicts unless fetch has been starved up to the limit.
  always_comb begin
    if_gnt_c  = 1'b0;
    mem_gnt_c = 1'b0;
    if (i_reset_n) begin
      if (bus.i_ifReq && (!bus.i_memReq || starve_hit_c)) if_gnt_c  = 1'b1;
      else if (bus.i_memReq)                              mem_gnt_c = 1'b1;
    end
  end

  assign bus.o_ifGnt     = if_gnt_c;
  assign bus.o_memGnt    = mem_gnt_c;
  assign bus.o_portEn    = if_gnt_c | mem_gnt_c;
  assign bus.o_portAddr  = mem_gnt_c ? bus.i_memAddr  : bus.i_ifAddr;
  assign bus.o_portWData = mem_gnt_c ? bus.i_memWData : '0;
  assign bus.o_portCtrl  = mem_gnt_c ? bus.i_ctrlMEM  : FETCH_CTRL;
  assign bus.o_stall     = (bus.i_ifReq & ~if_gnt_c) | (bus.i_memReq & ~mem_gnt_c);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) rsp_q <= RSP_NONE;
    else            rsp_q <= rsp_d;
  end

  // Next owner comes from this cycle's grant; outputs steer the returning word.
  always_comb begin
    rsp_d          = RSP_NONE;
    bus.o_ifValid  = 1'b0;
    bus.o_ifData   = '0;
    bus.o_memValid = 1'b0;
    bus.o_memRData = '0;

    if (if_gnt_c)       rsp_d = RSP_IF;
    else if (mem_gnt_c) rsp_d = bus.i_ctrlMEM.memWrite ? RSP_MEMWR : RSP_MEM;

    case (rsp_q)
      RSP_IF: begin
        bus.o_ifValid = 1'b1;
        bus.o_ifData  = bus.i_portRData;
      end
      RSP_MEM: begin
        bus.o_memValid = 1'b1;
        bus.o_memRData = bus.i_portRData;
      end
      RSP_MEMWR: bus.o_memValid = 1'b1;
      default: ;
    endcase
  end

`ifdef ARB_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cnt_conflict_q;
  logic [CNT_W-1:0] cnt_if_deny_q;
  logic [CNT_W-1:0] cnt_mem_deny_q;

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_conflict_q <= '0;
      cnt_if_deny_q  <= '0;
      cnt_mem_deny_q <= '0;
    end else begin
      if (bus.i_ifReq && bus.i_memReq && !(&cnt_conflict_q))
        cnt_conflict_q <= cnt_conflict_q + CNT_W'(1);
      if (bus.i_ifReq && !if_gnt_c && !(&cnt_if_deny_q))
        cnt_if_deny_q <= cnt_if_deny_q + CNT_W'(1);
      if (bus.i_memReq && !mem_gnt_c && !(&cnt_mem_deny_q))
        cnt_mem_deny_q <= cnt_mem_deny_q + CNT_W'(1);
    end
  end

  assign bus.o_cntConflict = cnt_conflict_q;
  assign bus.o_cntIfDeny   = cnt_if_deny_q;
  assign bus.o_cntMemDeny  = cnt_mem_deny_q;
`else
  assign bus.o_cntConflict = CNT_W'(0);
  assign bus.o_cntIfDeny   = CNT_W'(0);
  assign bus.o_cntMemDeny  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random
// traffic against a transaction-level reference model and a memory stub.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_W        = 32;
  localparam longint unsigned CNT_MAX  = 64'hFFFF_FFFF;

  logic i_clk;
  logic i_reset_n;

  mem_port_arbiter_if #(.CNT_W(CNT_W)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory stub seen by the DUT and the model's own copy of memory.
  logic [31:0] stub_mem [256];
  logic [31:0] ref_mem  [256];
  logic [31:0] rd_next;

  // Requester state (a request stays up until the model says it was accepted).
  bit          if_pend, mem_pend;
  logic [31:0] if_a, mem_a, mem_wd;
  mem_ctrl_t   mem_c;

  // Reference model state.
  int              m_starve;
  int              m_exp_rsp;    // 0 none, 1 fetch word, 2 load word, 3 store ack
  logic [31:0]     m_exp_data;
  longint unsigned m_cnt_conf, m_cnt_ifd, m_cnt_memd;
  bit              prev_rst;
  bit              started;

  mem_ctrl_t lw_c, sw_c;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v, input bit ev);
    return (ev && v != CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic run_cycle(input bit rst_n, input bit new_if, input logic [31:0] ia,
                           input bit new_mem, input logic [31:0] ma, input logic [31:0] wd,
                           input mem_ctrl_t c);
    bit          m_if_win, m_mem_win, conflict;
    logic [31:0] exp_cnt_c, exp_cnt_i, exp_cnt_m;
    int          idx;

    @(negedge i_clk);
    cyc++;
    i_reset_n = rst_n;
    if (new_if && !if_pend) begin
      if_pend = 1'b1;
      if_a    = ia;
    end
    if (new_mem && !mem_pend) begin
      mem_pend = 1'b1;
      mem_a    = ma;
      mem_wd   = wd;
      mem_c    = c;
    end
    bus.i_ifReq     = if_pend;
    bus.i_ifAddr    = if_a;
    bus.i_memReq    = mem_pend;
    bus.i_memAddr   = mem_a;
    bus.i_memWData  = mem_wd;
    bus.i_ctrlMEM   = mem_c;
    bus.i_portRData = rd_next;
    #1;

    // Arbitration decision from the rules: data first, fetch after LIMIT denials.
    conflict  = if_pend && mem_pend;
    m_if_win  = rst_n && if_pend && (!mem_pend || m_starve >= int'(STARVE_LIMIT));
    m_mem_win = rst_n && mem_pend && !m_if_win;

    check_val("if_gnt",  32'(bus.o_ifGnt),  32'(m_if_win));
    check_val("mem_gnt", 32'(bus.o_memGnt), 32'(m_mem_win));
    check_val("port_en", 32'(bus.o_portEn), 32'(m_if_win || m_mem_win));
    check_val("stall",   32'(bus.o_stall),
              32'((if_pend && !m_if_win) || (mem_pend && !m_mem_win)));
    if (m_mem_win) begin
      check_val("port_addr_mem", bus.o_portAddr, mem_a);
      check_val("port_wdata",    bus.o_portWData, mem_wd);
      check_val("port_ctrl",     32'(bus.o_portCtrl), 32'(mem_c));
    end else begin
      check_val("port_addr_if",  bus.o_portAddr, if_a);
      check_val("port_wr_if",    32'(bus.o_portCtrl.memWrite), 32'd0);
    end

    // The cycle in which reset first goes low still shows the pre-reset owner.
    if (!(rst_n == 1'b0 && prev_rst == 1'b1)) begin
      check_val("if_valid",  32'(bus.o_ifValid),  32'(m_exp_rsp == 1));
      check_val("if_data",   bus.o_ifData,  (m_exp_rsp == 1) ? m_exp_data : 32'd0);
      check_val("mem_valid", 32'(bus.o_memValid), 32'(m_exp_rsp == 2 || m_exp_rsp == 3));
      check_val("mem_rdata", bus.o_memRData, (m_exp_rsp == 2) ? m_exp_data : 32'd0);
    end

`ifdef ARB_PERF_COUNTERS_EN
    exp_cnt_c = 32'(m_cnt_conf);
    exp_cnt_i = 32'(m_cnt_ifd);
    exp_cnt_m = 32'(m_cnt_memd);
`else
    exp_cnt_c = 32'd0;
    exp_cnt_i = 32'd0;
    exp_cnt_m = 32'd0;
`endif
    if (started) begin
      check_val("cnt_conflict", 32'(bus.o_cntConflict), exp_cnt_c);
      check_val("cnt_if_deny",  32'(bus.o_cntIfDeny),   exp_cnt_i);
      check_val("cnt_mem_deny", 32'(bus.o_cntMemDeny),  exp_cnt_m);
    end

    // Memory stub reacts to what the DUT actually drives on the port.
    idx = int'(bus.o_portAddr[9:2]);
    if (bus.o_portEn === 1'b1 && bus.o_portCtrl.memWrite === 1'b0) rd_next = stub_mem[idx];
    else rd_next = $urandom;
    if (bus.o_portEn === 1'b1 && bus.o_portCtrl.memWrite === 1'b1) stub_mem[idx] = bus.o_portWData;

    // Model: the accepted access determines next cycle's response.
    m_exp_rsp = 0;
    if (m_if_win) begin
      m_exp_rsp  = 1;
      m_exp_data = ref_mem[int'(if_a[9:2])];
      if_pend    = 1'b0;
    end else if (m_mem_win) begin
      if (mem_c.memWrite) begin
        ref_mem[int'(mem_a[9:2])] = mem_wd;
        m_exp_rsp = 3;
      end else begin
        m_exp_rsp  = 2;
        m_exp_data = ref_mem[int'(mem_a[9:2])];
      end
      mem_pend = 1'b0;
    end

    if (!rst_n) begin
      m_starve   = 0;
      m_cnt_conf = 0;
      m_cnt_ifd  = 0;
      m_cnt_memd = 0;
    end else begin
      m_starve   = (bus.i_ifReq && !m_if_win) ?
                   ((m_starve + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : m_starve + 1) : 0;
      m_cnt_conf = sat_inc(m_cnt_conf, conflict);
      m_cnt_ifd  = sat_inc(m_cnt_ifd,  bus.i_ifReq && !m_if_win);
      m_cnt_memd = sat_inc(m_cnt_memd, bus.i_memReq && !m_mem_win);
    end
    prev_rst = rst_n;
    started  = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lw_c);
  endtask

  initial begin
    i_clk     = 1'b0;
    i_reset_n = 1'b0;
    lw_c = '{size: 2'b10, sign: 1'b0, memWrite: 1'b0};
    sw_c = '{size: 2'b10, sign: 1'b0, memWrite: 1'b1};
    for (int i = 0; i < 256; i++) begin
      stub_mem[i] = $urandom;
      ref_mem[i]  = stub_mem[i];
    end
    rd_next = 32'd0;
    if_pend = 1'b0; mem_pend = 1'b0;
    if_a = 32'd0; mem_a = 32'd0; mem_wd = 32'd0; mem_c = lw_c;
    m_starve = 0; m_exp_rsp = 0; m_exp_data = 32'd0;
    m_cnt_conf = 0; m_cnt_ifd = 0; m_cnt_memd = 0;
    prev_rst = 1'b1; started = 1'b0;
    bus.i_ifReq = 1'b0; bus.i_ifAddr = '0; bus.i_memReq = 1'b0; bus.i_memAddr = '0;
    bus.i_memWData = '0; bus.i_ctrlMEM = lw_c; bus.i_portRData = '0;

    // Reset with a request already waiting: no grants while reset is low.
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lw_c);
    run_cycle(1'b0, 1'b1, 32'h8, 1'b0, 32'd0, 32'd0, lw_c);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lw_c);
    idle(2);

    // Fetch only, back to back.
    run_cycle(1'b1, 1'b1, 32'h10, 1'b0, 32'd0, 32'd0, lw_c);
    run_cycle(1'b1, 1'b1, 32'h14, 1'b0, 32'd0, 32'd0, lw_c);
    run_cycle(1'b1, 1'b1, 32'h18, 1'b0, 32'd0, 32'd0, lw_c);
    idle(1);

    // Conflict: load wins, fetch waits one cycle.
    run_cycle(1'b1, 1'b1, 32'h0, 1'b1, 32'h100, 32'd0, lw_c);
    idle(2);

    // Continuous conflict: fetch forced through every fifth cycle.
    for (int k = 0; k < 10; k++)
      run_cycle(1'b1, 1'b1, 32'(k * 4), 1'b1, 32'(32'h180 + k * 4), 32'd0, lw_c);
    idle(2);

    // Store then load of the same word.
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 32'hDEADBEEF, sw_c);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 32'd0, lw_c);
    idle(2);

    // Reset right after a load is granted drops the response.
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 32'd0, lw_c);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lw_c);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lw_c);
    idle(2);

    // Random traffic with varying request densities and occasional reset.
    for (int k = 0; k < 2000; k++) begin
      int        if_rate, mem_rate;
      mem_ctrl_t rc;
      if_rate  = 20 + ((k / 250) * 13) % 80;
      mem_rate = 90 - ((k / 250) * 17) % 80;
      rc.size     = 2'($urandom_range(0, 2));
      rc.sign     = 1'($urandom_range(0, 1));
      rc.memWrite = 1'($urandom_range(0, 1));
      run_cycle($urandom_range(0, 149) != 0,
                $urandom_range(0, 99) < if_rate,  32'($urandom_range(0, 255)) << 2,
                $urandom_range(0, 99) < mem_rate, 32'($urandom_range(0, 255)) << 2,
                $urandom, rc);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
